sbuff_drain_ctrl: RTL
=====================

Name: sbuff_drain_ctrl

Overview:
- Sequences draining of committed stores from the store buffer into the D-cache write port, strictly in sbuff-ID order.
- Sits between the dispatch store-ID allocator and the DCU.
  - Consumes the allocator's committed (rec) pointer.
  - Issues one store write request per handshake.
  - Returns one `o_exu_dsp_s_ret` pulse per acknowledged store, which advances the allocator's read pointer and frees the ID.
- Also provides a fence-done indication and a trap-flush sequence.

Parameters:
- SBUFF_ID_WIDTH, 6: ID/pointer width. The MSB is the wrap bit; the pool is 2^(SBUFF_ID_WIDTH-1) = 32 entries.
- MAX_OUTST, 2: maximum DCU store requests outstanding without an ack (1..3).
- OUTST_W, 2: width of the outstanding counter; must satisfy 2^OUTST_W > MAX_OUTST.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset (decided: one clock; reset is synchronous and active-high).
- i_csr_trap_flush  in  1  trap flush; the allocator pointers go to 0 in the same cycle.
- i_stq_rec_id  in  SBUFF_ID_WIDTH  committed pointer from the allocator (`o_dsp_stq_req_rec_id`).
- i_dcu_st_rdy  in  1  DCU can accept a store request this cycle.
- i_dcu_st_ack  in  1  DCU completed the oldest outstanding store (in-order acks).
- i_fence_req  in  1  level; the fence waits for the drain to complete.
- o_dcu_st_vld  out  1  store request valid.
- o_dcu_st_id  out  SBUFF_ID_WIDTH  sbuff ID of the request; the low 5 bits index the buffer.
- o_exu_dsp_s_ret  out  1  one-cycle pulse per drained store, to the allocator read pointer.
- o_fence_done  out  1  no committed store is undrained.
- o_busy  out  1  state != IDLE.
- o_ack_err  out  1  sticky: an ack arrived with zero outstanding.

Behaviour:
- State registers: FSM state; `iss_ptr` (next ID to issue, SBUFF_ID_WIDTH bits); `outst` (OUTST_W bits); registered `s_ret`; sticky `ack_err`.
- Reset (rst=1 at a clock edge) sets state=IDLE, iss_ptr=0, outst=0, o_exu_dsp_s_ret=0, o_ack_err=0.
  - Therefore o_dcu_st_vld=0, o_fence_done=1, o_busy=0 after reset.
  - Reset mid-request drops the request with no ack accounting.
- Pending count: `pend = i_stq_rec_id - iss_ptr`, computed modulo 2^SBUFF_ID_WIDTH.
  - pend>32 cannot occur. No check is made for it.
- Request fire: `fire = o_dcu_st_vld & i_dcu_st_rdy`.
  - o_dcu_st_vld = (state==RUN) & (pend!=0) & (outst<MAX_OUTST). It is combinational.
  - o_dcu_st_id = iss_ptr. It must stay stable while vld=1 and rdy=0 (no flush).
- On fire, iss_ptr += 1 (wraps naturally at 2^SBUFF_ID_WIDTH).
- outst update: +1 on fire, -1 on ack. Simultaneous fire and ack leave it unchanged.
- Ack with outst==0 (and no fire that same cycle): the ack is ignored and o_ack_err is set, sticky until rst.
- o_exu_dsp_s_ret is registered: it pulses the cycle after each accepted ack in RUN/IDLE. Latency ack -> s_ret is 1 cycle.
  - Back-to-back acks give back-to-back pulses.
- FSM:
  - IDLE -> RUN when pend!=0.
  - RUN -> IDLE when pend==0 & outst==0 (after the decrement).
  - Any state -> FLUSH on i_csr_trap_flush. Flush has priority over all other events in the same cycle.
- FLUSH:
  - On entry, iss_ptr=0.
  - o_dcu_st_vld=0.
  - Acks received in FLUSH decrement outst but produce no s_ret. The allocator rd_ptr was already zeroed, so a pulse would corrupt it.
  - A pending s_ret from the cycle before the flush is suppressed.
  - FLUSH -> IDLE when outst==0.
  - A flush arriving while already in FLUSH restarts nothing; it stays in FLUSH.
  - A flush with outst==0 returns to IDLE the next cycle.
- o_fence_done = (state!=FLUSH) & (pend==0) & (outst==0) & ~s_ret_pending.
  - i_fence_req only gates nothing internally; the requester polls done.
  - It is kept as an input so a fence forces RUN even in a future low-power IDLE. For now: when i_fence_req=1 & pend!=0, the block must reach RUN within 1 cycle, which it does by the normal IDLE->RUN rule.
- o_busy = state!=IDLE.

Decomposition:
- Shared package: SBUFF_ID_WIDTH/pool-size defines (reuse the existing global defines), the FSM state encoding localparams (IDLE=2'd0, RUN=2'd1, FLUSH=2'd2), and MAX_OUTST.
- One natural sub-module: `sbuff_outst_cnt`, a saturating-checked up/down counter producing outst, ack_err, and the cnt==0 / cnt<MAX flags.
- Everything else stays flat; target roughly 180 RTL lines.

Test Plan:
- Reset, then rec_id 0->3 with rdy=1 and ack 2 cycles after each fire -> IDs 0,1,2 issued; at most 2 outstanding; three s_ret pulses, each 1 cycle after its ack; fence_done=1 afterwards; state back to IDLE.
- rec_id=5 with rdy held 0 for 4 cycles -> vld=1 with id=0 stable for 4 cycles; fire on the 5th cycle; iss_ptr=1.
- Wrap: force iss_ptr/rec progression 62 -> rec=2 -> IDs issued 62,63,0,1; pend computed 4 at start; no spurious stop.
- Trap flush with outst=2 and rec=10, iss=4 -> vld drops the same cycle; state=FLUSH; two later acks produce no s_ret; IDLE after the second ack; iss_ptr=0; fence_done=1.
- Ack with outst=0 -> o_ack_err=1 and stays set; no s_ret; counter stays 0.
- Simultaneous fire and ack at outst=1 -> outst stays 1; s_ret pulse next cycle; iss_ptr increments.

Source files
------------

// File: rtl/sbuff_drain_ctrl_pkg.sv
// Shared sizing and FSM encoding for the store-buffer drain controller.
package sbuff_drain_ctrl_pkg;

    localparam int unsigned SBUFF_ID_WIDTH = 6;
    localparam int unsigned SBUFF_POOL     = 1 << (SBUFF_ID_WIDTH - 1);
    localparam int unsigned MAX_OUTST      = 2;
    localparam int unsigned OUTST_W        = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StFlush = 2'd2
    } drain_state_e;

endpackage

// File: rtl/sbuff_outst_cnt.sv
// Outstanding DCU store counter: +1 per issued request, -1 per accepted ack,
// with a sticky error for acks that arrive when nothing is in flight.
module sbuff_outst_cnt
    import sbuff_drain_ctrl_pkg::*;
#(
    parameter int unsigned MaxOutst = MAX_OUTST,
    parameter int unsigned OutstW   = OUTST_W
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic dec_ok_o,
    output logic zero_o,
    output logic below_max_o,
    output logic next_zero_o,
    output logic err_o
);

    localparam logic [OutstW-1:0] MaxVal = OutstW'(MaxOutst);

    logic [OutstW-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              dec_ok;

    // An ack paired with a same-cycle issue is legal even from zero.
    assign dec_ok = dec_i & ((cnt_q != '0) | inc_i);

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q | (dec_i & ~dec_ok);
        unique case ({inc_i, dec_ok})
            2'b10: begin
                if (cnt_q < MaxVal) begin
                    cnt_d = cnt_q + OutstW'(1);
                end
            end
            2'b01:   cnt_d = cnt_q - OutstW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign dec_ok_o    = dec_ok;
    assign zero_o      = (cnt_q == '0);
    assign below_max_o = (cnt_q < MaxVal);
    assign next_zero_o = (cnt_d == '0);
    assign err_o       = err_q;

endmodule

// File: rtl/sbuff_drain_ctrl.sv
// Drains committed stores from the store buffer to the D-cache in ID order and
// returns one s_ret pulse per acknowledged store to the ID allocator.
module sbuff_drain_ctrl
    import sbuff_drain_ctrl_pkg::*;
#(
    parameter int unsigned SbuffIdWidth = SBUFF_ID_WIDTH,
    parameter int unsigned MaxOutst     = MAX_OUTST,
    parameter int unsigned OutstW       = OUTST_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_csr_trap_flush,
    input  logic [SbuffIdWidth-1:0] i_stq_rec_id,
    input  logic                    i_dcu_st_rdy,
    input  logic                    i_dcu_st_ack,
    input  logic                    i_fence_req,
    output logic                    o_dcu_st_vld,
    output logic [SbuffIdWidth-1:0] o_dcu_st_id,
    output logic                    o_exu_dsp_s_ret,
    output logic                    o_fence_done,
    output logic                    o_busy,
    output logic                    o_ack_err
);

    drain_state_e            state_q, state_d;
    logic [SbuffIdWidth-1:0] iss_ptr_q, iss_ptr_d;
    logic                    s_ret_q, s_ret_d;

    logic [SbuffIdWidth-1:0] pend;
    logic                    has_pend;
    logic                    wake;
    logic                    fire;
    logic                    ack_ok;
    logic                    outst_zero;
    logic                    outst_below_max;
    logic                    outst_next_zero;

    assign pend     = i_stq_rec_id - iss_ptr_q;
    assign has_pend = (pend != '0);
    // Fence hook: a fence with pending stores wakes exactly like plain pending work.
    assign wake     = has_pend | (i_fence_req & has_pend);

    assign o_dcu_st_vld = (state_q == StRun) & has_pend & outst_below_max & ~i_csr_trap_flush;
    assign fire         = o_dcu_st_vld & i_dcu_st_rdy;

    sbuff_outst_cnt #(
        .MaxOutst (MaxOutst),
        .OutstW   (OutstW)
    ) u_outst_cnt (
        .clk_i       (clk),
        .rst_i       (rst),
        .inc_i       (fire),
        .dec_i       (i_dcu_st_ack),
        .dec_ok_o    (ack_ok),
        .zero_o      (outst_zero),
        .below_max_o (outst_below_max),
        .next_zero_o (outst_next_zero),
        .err_o       (o_ack_err)
    );

    always_comb begin
        state_d   = state_q;
        iss_ptr_d = iss_ptr_q;
        // Allocator pointers are zeroed on flush, so no return may reach them.
        s_ret_d   = ack_ok & (state_q != StFlush) & ~i_csr_trap_flush;

        if (fire) begin
            iss_ptr_d = iss_ptr_q + SbuffIdWidth'(1);
        end

        if (i_csr_trap_flush) begin
            state_d   = StFlush;
            iss_ptr_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (wake) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (!has_pend && outst_next_zero) begin
                        state_d = StIdle;
                    end
                end
                StFlush: begin
                    if (outst_next_zero) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            iss_ptr_q <= '0;
            s_ret_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            iss_ptr_q <= iss_ptr_d;
            s_ret_q   <= s_ret_d;
        end
    end

    assign o_dcu_st_id     = iss_ptr_q;
    assign o_exu_dsp_s_ret = s_ret_q & ~i_csr_trap_flush;
    assign o_fence_done    = (state_q != StFlush) & ~has_pend & outst_zero & ~s_ret_q;
    assign o_busy          = (state_q != StIdle);

endmodule
